d_branch_unit: RTL and testbench



---
 rtl/rv_pkg.sv | 24 ++
 rtl/br_cond.sv | 33 +++
 rtl/d_branch_unit.sv | 190 +++++++++++++++++++
 tb/tb_d_branch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I control-flow encodings for the decode-stage branch unit.
//   JC_*  : two-bit jump_code values presented by decode per slot.
//   F3_*  : branch funct3 values understood by the br_cond comparator.
//   br_state_t : redirect/shadow FSM states of d_branch_unit.
package rv_pkg;

  localparam logic [1:0] JC_NONE = 2'b00;
  localparam logic [1:0] JC_BR   = 2'b01;
  localparam logic [1:0] JC_JAL  = 2'b10;
  localparam logic [1:0] JC_JALR = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SHADOW = 1'b1
  } br_state_t;

endpackage

// File: rtl/br_cond.sv
// br_cond: combinational RV32I branch condition evaluator.
//   rs1, rs2 : 32-bit operands
//   funct3   : branch funct3
//   flag     : 1 when the branch condition holds; 0 for undefined funct3
module br_cond
  import rv_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  output logic        flag
);

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  always_comb begin
    flag = 1'b0;
    case (funct3)
      F3_BEQ:  flag = (rs1 == rs2);
      F3_BNE:  flag = (rs1 != rs2);
      F3_BLT:  flag = (rs1_s <  rs2_s);
      F3_BGE:  flag = (rs1_s >= rs2_s);
      F3_BLTU: flag = (rs1 <  rs2);
      F3_BGEU: flag = (rs1 >= rs2);
      default: flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_unit.sv
// d_branch_unit: decode-stage control-flow resolver.
// Picks the oldest (lowest-index) valid control-flow slot, computes its true
// next PC and compares it with fetch's prediction. A mismatch produces a
// registered one-cycle redirect and then masks decode for SHADOW_CYC cycles.
// Saturating counters track resolved and mispredicted instructions.
// Optional feature macro: D_BRANCH_UNIT_BHT_EN adds a 2-bit counter BHT
// queried combinationally by fetch through lookup_pc / lookup_taken.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   ctrl_valid[ISSUE_W]   : slot holds a control-flow instruction
//   pc_i, rs1_i, rs2_i, imm_i, jump_code_i, branch_code_i : packed per-slot fields
//   pc_predicted          : fetch's predicted successor of the resolving slot
//   cannot_calcpc         : operand hazard, suppresses resolution
//   redirect, redirect_pc, redirect_slot : registered mispredict pulse + data
//   shadow                : decode slots are wrong-path this cycle
//   br_count, mp_count    : saturating statistics
//   lookup_pc, lookup_taken : BHT query (D_BRANCH_UNIT_BHT_EN only)
module d_branch_unit
  import rv_pkg::*;
#(
  parameter int ISSUE_W    = 2,
  parameter int PC_W       = 13,
  parameter int SHADOW_CYC = 1,
  parameter int BHT_IDX_W  = 6,
  parameter int CNT_W      = 16,
  localparam int SLOT_W    = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ISSUE_W-1:0]    ctrl_valid,
  input  logic [ISSUE_W*PC_W-1:0] pc_i,
  input  logic [ISSUE_W*32-1:0] rs1_i,
  input  logic [ISSUE_W*32-1:0] rs2_i,
  input  logic [ISSUE_W*32-1:0] imm_i,
  input  logic [ISSUE_W*2-1:0]  jump_code_i,
  input  logic [ISSUE_W*3-1:0]  branch_code_i,
  input  logic [PC_W-1:0]       pc_predicted,
  input  logic                  cannot_calcpc,
  output logic                  redirect,
  output logic [PC_W-1:0]       redirect_pc,
  output logic [SLOT_W-1:0]     redirect_slot,
  output logic                  shadow,
  output logic [CNT_W-1:0]      br_count,
  output logic [CNT_W-1:0]      mp_count
`ifdef D_BRANCH_UNIT_BHT_EN
  ,
  input  logic [PC_W-1:0]       lookup_pc,
  output logic                  lookup_taken
`endif
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SLOT_W-1:0] sel_slot;
  logic [PC_W-1:0]   sel_pc;
  logic [31:0]       sel_rs1;
  logic [31:0]       sel_rs2;
  logic [31:0]       sel_imm;
  logic [1:0]        sel_jc;
  logic [2:0]        sel_f3;

  // Walk from youngest to oldest so the lowest valid index wins.
  always_comb begin
    sel_slot = '0;
    sel_pc   = '0;
    sel_rs1  = '0;
    sel_rs2  = '0;
    sel_imm  = '0;
    sel_jc   = JC_NONE;
    sel_f3   = '0;
    for (int i = ISSUE_W - 1; i >= 0; i--) begin
      if (ctrl_valid[i]) begin
        sel_slot = SLOT_W'(i);
        sel_pc   = pc_i[i*PC_W +: PC_W];
        sel_rs1  = rs1_i[i*32 +: 32];
        sel_rs2  = rs2_i[i*32 +: 32];
        sel_imm  = imm_i[i*32 +: 32];
        sel_jc   = jump_code_i[i*2 +: 2];
        sel_f3   = branch_code_i[i*3 +: 3];
      end
    end
  end

  logic flag;

  br_cond u_cond (
    .rs1    (sel_rs1),
    .rs2    (sel_rs2),
    .funct3 (sel_f3),
    .flag   (flag)
  );

  br_state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  logic            res;
  logic            taken;
  logic            mp;
  logic [PC_W-1:0] base;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] true_pc;

  assign shadow  = (state == ST_SHADOW);
  assign res     = (|ctrl_valid) & ~cannot_calcpc & ~shadow & (sel_jc != JC_NONE);
  // Byte immediates and jalr base are converted to word addresses by dropping bits [1:0].
  assign base    = (sel_jc == JC_JALR) ? sel_rs1[PC_W+1:2] : sel_pc;
  assign target  = sel_imm[PC_W+1:2] + base;
  assign taken   = (sel_jc == JC_JAL) | (sel_jc == JC_JALR) | ((sel_jc == JC_BR) & flag);
  assign true_pc = taken ? target : sel_pc + PC_W'(1);
  assign mp      = res & (true_pc != pc_predicted);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (mp) begin
          state_nxt = ST_SHADOW;
          cnt_nxt   = 2'(SHADOW_CYC);
        end
      end
      ST_SHADOW: begin
        cnt_nxt = cnt - 2'd1;
        if (cnt <= 2'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Redirect register: pulse for one cycle, payload held between mispredicts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      redirect_slot <= '0;
      br_count      <= '0;
      mp_count      <= '0;
    end else begin
      redirect <= mp;
      if (mp) begin
        redirect_pc   <= true_pc;
        redirect_slot <= sel_slot;
        mp_count      <= sat_inc(mp_count);
      end
      if (res) br_count <= sat_inc(br_count);
    end
  end

`ifdef D_BRANCH_UNIT_BHT_EN
  localparam int BHT_N = 1 << BHT_IDX_W;

  function automatic logic [1:0] bht_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [1:0] bht [BHT_N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht[i[BHT_IDX_W-1:0]] <= 2'b01;
    end else if (res && (sel_jc == JC_BR)) begin
      bht[sel_pc[BHT_IDX_W-1:0]] <= bht_step(bht[sel_pc[BHT_IDX_W-1:0]], flag);
    end
  end

  // Combinational read sees the pre-edge contents during a same-cycle update.
  assign lookup_taken = bht[lookup_pc[BHT_IDX_W-1:0]][1];

  logic unused_bits;
  assign unused_bits = ^{sel_imm[31:PC_W+2], sel_imm[1:0], lookup_pc};
`else
  localparam int UNUSED_BHT_IDX_W = BHT_IDX_W;
  logic unused_bits;
  assign unused_bits = ^{sel_imm[31:PC_W+2], sel_imm[1:0]};
`endif

endmodule

// File: tb/tb_d_branch_unit.sv
module tb_d_branch_unit;
  import rv_pkg::*;

  localparam int IW = 2;
  localparam int PW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [IW-1:0]      ctrl_valid;
  logic [IW*PW-1:0]   pc_i;
  logic [IW*32-1:0]   rs1_i, rs2_i, imm_i;
  logic [IW*2-1:0]    jump_code_i;
  logic [IW*3-1:0]    branch_code_i;
  logic [PW-1:0]      pc_predicted;
  logic               cannot_calcpc;

  logic               redirect, redirect2;
  logic [PW-1:0]      redirect_pc, redirect_pc2;
  logic               redirect_slot, redirect_slot2;
  logic               shadow, shadow2;
  logic [15:0]        br_count, mp_count;
  logic [2:0]         br_count2, mp_count2;
`ifdef D_BRANCH_UNIT_BHT_EN
  logic [PW-1:0]      lookup_pc;
  logic               lookup_taken, lookup_taken2;
`endif

  d_branch_unit #(.ISSUE_W(IW), .PC_W(PW), .SHADOW_CYC(1), .BHT_IDX_W(6), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid), .pc_i(pc_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .imm_i(imm_i), .jump_code_i(jump_code_i), .branch_code_i(branch_code_i),
    .pc_predicted(pc_predicted), .cannot_calcpc(cannot_calcpc), .redirect(redirect),
    .redirect_pc(redirect_pc), .redirect_slot(redirect_slot), .shadow(shadow),
    .br_count(br_count), .mp_count(mp_count)
`ifdef D_BRANCH_UNIT_BHT_EN
    , .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
`endif
  );

  d_branch_unit #(.ISSUE_W(IW), .PC_W(PW), .SHADOW_CYC(2), .BHT_IDX_W(6), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ctrl_valid(ctrl_valid), .pc_i(pc_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .imm_i(imm_i), .jump_code_i(jump_code_i), .branch_code_i(branch_code_i),
    .pc_predicted(pc_predicted), .cannot_calcpc(cannot_calcpc), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .redirect_slot(redirect_slot2), .shadow(shadow2),
    .br_count(br_count2), .mp_count(mp_count2)
`ifdef D_BRANCH_UNIT_BHT_EN
    , .lookup_pc(lookup_pc), .lookup_taken(lookup_taken2)
`endif
  );

  typedef struct {
    logic [PW-1:0] pc;
    logic [31:0]   rs1, rs2, imm;
    logic [1:0]    jc;
    logic [2:0]    f3;
  } slot_t;

  typedef struct {
    string         name;
    logic [1:0]    v;
    slot_t         s0, s1;
    logic [PW-1:0] pred;
    logic          cc;
    logic          e_res;
    logic          e_red;
    logic [PW-1:0] e_pc;
    logic          e_slot;
  } vec_t;

  typedef struct {
    logic          red;
    logic [PW-1:0] pc;
    logic          slot;
    logic          shd;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[$];

  int checks = 0;
  int failures = 0;
  int exp_br = 0, exp_mp = 0, exp_br2 = 0, exp_mp2 = 0;
  logic [PW-1:0] last_pc = '0;
  logic          last_slot = 1'b0;

  function automatic slot_t mk(logic [PW-1:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                               logic [31:0] imm, logic [1:0] jc, logic [2:0] f3);
    slot_t s;
    s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm; s.jc = jc; s.f3 = f3;
    return s;
  endfunction

  function automatic vec_t mkv(string n, logic [1:0] v, slot_t a, slot_t b, logic [PW-1:0] pred,
                               logic cc, logic er, logic ed, logic [PW-1:0] epc, logic es);
    vec_t x;
    x.name = n; x.v = v; x.s0 = a; x.s1 = b; x.pred = pred; x.cc = cc;
    x.e_res = er; x.e_red = ed; x.e_pc = epc; x.e_slot = es;
    return x;
  endfunction

  function automatic int sat7(int x);
    return (x > 7) ? 7 : x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic check_counts(string tag);
    chk({tag, "_br_count"}, 32'(br_count), exp_br);
    chk({tag, "_mp_count"}, 32'(mp_count), exp_mp);
    chk({tag, "_br_count_sat"}, 32'(br_count2), sat7(exp_br2));
    chk({tag, "_mp_count_sat"}, 32'(mp_count2), sat7(exp_mp2));
  endtask

  task automatic put_slot(int i, slot_t s);
    pc_i[i*PW +: PW]         = s.pc;
    rs1_i[i*32 +: 32]        = s.rs1;
    rs2_i[i*32 +: 32]        = s.rs2;
    imm_i[i*32 +: 32]        = s.imm;
    jump_code_i[i*2 +: 2]    = s.jc;
    branch_code_i[i*3 +: 3]  = s.f3;
  endtask

  task automatic set_idle();
    ctrl_valid = '0; pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    jump_code_i = '0; branch_code_i = '0; pc_predicted = '0; cannot_calcpc = 1'b0;
  endtask

  task automatic drive(vec_t v);
    ctrl_valid = v.v;
    put_slot(0, v.s0);
    put_slot(1, v.s1);
    pc_predicted = v.pred;
    cannot_calcpc = v.cc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    slot_t nop;
    exp_t e;
    vec_t v;
    nop = mk(0, 0, 0, 0, JC_NONE, 0);

    vt.push_back(mkv("beq_taken_mp", 2'b01, mk(13'h10, 5, 5, 32'h20, JC_BR, F3_BEQ), nop, 13'h11, 0, 1, 1, 13'h18, 0));
    vt.push_back(mkv("oldest_wins", 2'b11, mk(13'h10, 5, 5, 32'h20, JC_BR, F3_BNE),
                     mk(13'h11, 0, 0, 32'h40, JC_JAL, 0), 13'h11, 0, 1, 0, 0, 0));
    vt.push_back(mkv("jalr_wrap", 2'b01, mk(13'h20, 32'h1FFFC, 0, 32'h8, JC_JALR, 0), nop, 13'h21, 0, 1, 1, 13'h0001, 0));
    vt.push_back(mkv("blt_slot1", 2'b10, nop, mk(13'h100, 32'hFFFFFFFF, 1, 32'h10, JC_BR, F3_BLT), 13'h101, 0, 1, 1, 13'h104, 1));
    vt.push_back(mkv("bltu_not_taken", 2'b01, mk(13'h200, 32'hFFFFFFFF, 1, 32'h10, JC_BR, F3_BLTU), nop, 13'h204, 0, 1, 1, 13'h201, 0));
    vt.push_back(mkv("bge_ok", 2'b01, mk(13'h30, 32'hFFFFFFFF, 1, 32'h40, JC_BR, F3_BGE), nop, 13'h31, 0, 1, 0, 0, 0));
    vt.push_back(mkv("bgeu_neg_imm", 2'b01, mk(13'h30, 32'hFFFFFFFF, 1, 32'hFFFFFFF8, JC_BR, F3_BGEU), nop, 13'h2E, 0, 1, 0, 0, 0));
    vt.push_back(mkv("bad_f3", 2'b01, mk(13'h40, 0, 0, 32'h20, JC_BR, 3'b010), nop, 13'h48, 0, 1, 1, 13'h41, 0));
    vt.push_back(mkv("bne_taken", 2'b01, mk(13'h60, 5, 6, 32'h8, JC_BR, F3_BNE), nop, 13'h61, 0, 1, 1, 13'h62, 0));
    vt.push_back(mkv("jc_none", 2'b01, mk(13'h10, 0, 0, 32'h20, JC_NONE, 0), nop, 13'h999, 0, 0, 0, 0, 0));
    vt.push_back(mkv("no_valid", 2'b00, mk(13'h10, 0, 0, 32'h20, JC_JAL, 0), nop, 13'h11, 0, 0, 0, 0, 0));
    vt.push_back(mkv("hazard", 2'b01, mk(13'h10, 0, 0, 32'h20, JC_JAL, 0), nop, 13'h11, 1, 0, 0, 0, 0));
    vt.push_back(mkv("pc_inc_wrap", 2'b01, mk(13'h1FFF, 3, 3, 32'h20, JC_BR, F3_BNE), nop, 13'h0, 0, 1, 0, 0, 0));
    vt.push_back(mkv("jal_wrap_ok", 2'b01, mk(13'h1FF0, 0, 0, 32'h40, JC_JAL, 0), nop, 13'h0, 0, 1, 0, 0, 0));
    vt.push_back(mkv("jal_slot1_mp", 2'b10, nop, mk(13'h80, 0, 0, 32'h8, JC_JAL, 0), 13'h81, 0, 1, 1, 13'h82, 1));

    set_idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    chk("reset_redirect", 32'(redirect), 0);
    chk("reset_redirect_pc", 32'(redirect_pc), 0);
    chk("reset_redirect_slot", 32'(redirect_slot), 0);
    chk("reset_shadow", 32'(shadow), 0);
    chk("reset_shadow2", 32'(shadow2), 0);
    check_counts("reset");

`ifdef D_BRANCH_UNIT_BHT_EN
    lookup_pc = 13'h40;
    #1;
    chk("bht_reset_lookup", 32'(lookup_taken), 0);
    for (int k = 0; k < 3; k++) begin
      drive(mkv("bht_t", 2'b01, mk(13'h40, 7, 7, 32'h10, JC_BR, F3_BEQ), nop, 13'h44, 0, 1, 0, 0, 0));
      #1;
      if (k == 0) chk("bht_read_during_write_old", 32'(lookup_taken), 0);
      tick();
      exp_br++; exp_br2++;
      chk("bht_taken_after_inc", 32'(lookup_taken), 1);
      chk("bht_no_redirect", 32'(redirect), 0);
    end
    drive(mkv("bht_nt", 2'b01, mk(13'h40, 7, 7, 32'h10, JC_BR, F3_BNE), nop, 13'h41, 0, 1, 0, 0, 0));
    tick();
    chk("bht_from_sat_dec1", 32'(lookup_taken), 1);
    tick();
    exp_br += 2; exp_br2 += 2;
    chk("bht_from_sat_dec2", 32'(lookup_taken), 0);
    drive(mkv("bht_t2", 2'b01, mk(13'h40, 7, 7, 32'h10, JC_BR, F3_BEQ), nop, 13'h44, 0, 1, 0, 0, 0));
    tick();
    set_idle();
    chk("bht_retaken", 32'(lookup_taken), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_br = 0; exp_br2 = 0;
    chk("bht_after_reset", 32'(lookup_taken), 0);
    check_counts("bht_reset");
`endif

    // Table-driven single-cycle vectors, each followed by enough idle cycles
    // for both instances to leave their shadows.
    for (int k = 0; k < vt.size(); k++) begin
      v = vt[k];
      drive(v);
      e.red  = v.e_red;
      e.pc   = v.e_red ? v.e_pc : last_pc;
      e.slot = v.e_red ? v.e_slot : last_slot;
      e.shd  = v.e_red;
      sbq.push_back(e);
      if (v.e_res) begin exp_br++; exp_br2++; end
      if (v.e_red) begin exp_mp++; exp_mp2++; end
      tick();
      set_idle();
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s scoreboard_empty", v.name);
      end else begin
        e = sbq.pop_front();
        chk({v.name, "_redirect"}, 32'(redirect), 32'(e.red));
        chk({v.name, "_redirect_pc"}, 32'(redirect_pc), 32'(e.pc));
        chk({v.name, "_redirect_slot"}, 32'(redirect_slot), 32'(e.slot));
        chk({v.name, "_shadow"}, 32'(shadow), 32'(e.shd));
        chk({v.name, "_redirect2"}, 32'(redirect2), 32'(e.red));
        chk({v.name, "_redirect_pc2"}, 32'(redirect_pc2), 32'(e.pc));
        chk({v.name, "_shadow2"}, 32'(shadow2), 32'(e.shd));
        last_pc = e.pc;
        last_slot = e.slot;
      end
      tick();
      chk({v.name, "_pulse_end"}, 32'(redirect), 0);
      chk({v.name, "_shadow_end"}, 32'(shadow), 0);
      chk({v.name, "_pc_hold"}, 32'(redirect_pc), 32'(last_pc));
      chk({v.name, "_shadow2_2nd"}, 32'(shadow2), 32'(v.e_red));
      tick();
      chk({v.name, "_shadow2_end"}, 32'(shadow2), 0);
      check_counts(v.name);
    end

    // Operand hazard held for three cycles, then released.
    drive(mkv("hz", 2'b01, mk(13'h50, 1, 2, 32'h40, JC_BR, F3_BLTU), nop, 13'h51, 1, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hazard_no_redirect", 32'(redirect), 0);
      check_counts("hazard_hold");
    end
    cannot_calcpc = 1'b0;
    tick();
    set_idle();
    exp_br++; exp_mp++; exp_br2++; exp_mp2++;
    chk("hazard_release_redirect", 32'(redirect), 1);
    chk("hazard_release_pc", 32'(redirect_pc), 32'h60);
    check_counts("hazard_release");
    tick();
    chk("hazard_pulse_end", 32'(redirect), 0);
    tick();
    last_pc = 13'h60; last_slot = 1'b0;

    // Mispredicting inputs held through the shadow: the 1-cycle-shadow
    // instance resolves again at N+2, the 2-cycle one does not.
    drive(mkv("sh", 2'b01, mk(13'h70, 0, 0, 32'h20, JC_JAL, 0), nop, 13'h71, 0, 1, 1, 13'h78, 0));
    tick();
    chk("sh_n1_redirect", 32'(redirect), 1);
    chk("sh_n1_pc", 32'(redirect_pc), 32'h78);
    chk("sh_n1_shadow", 32'(shadow), 1);
    chk("sh_n1_redirect2", 32'(redirect2), 1);
    chk("sh_n1_shadow2", 32'(shadow2), 1);
    tick();
    chk("sh_n2_redirect", 32'(redirect), 0);
    chk("sh_n2_shadow", 32'(shadow), 0);
    chk("sh_n2_redirect2", 32'(redirect2), 0);
    chk("sh_n2_shadow2", 32'(shadow2), 1);
    tick();
    set_idle();
    chk("sh_n3_redirect_again", 32'(redirect), 1);
    chk("sh_n3_shadow", 32'(shadow), 1);
    chk("sh_n3_redirect2", 32'(redirect2), 0);
    chk("sh_n3_shadow2", 32'(shadow2), 0);
    exp_br += 2; exp_mp += 2; exp_br2 += 1; exp_mp2 += 1;
    tick();
    chk("sh_n4_shadow", 32'(shadow), 0);
    check_counts("shadow_seq");

    // Reset while the 2-cycle shadow is active.
    drive(mkv("rs", 2'b01, mk(13'h70, 0, 0, 32'h20, JC_JAL, 0), nop, 13'h71, 0, 1, 1, 13'h78, 0));
    tick();
    set_idle();
    chk("mid_shadow_active2", 32'(shadow2), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_br = 0; exp_mp = 0; exp_br2 = 0; exp_mp2 = 0;
    chk("mid_reset_shadow", 32'(shadow), 0);
    chk("mid_reset_shadow2", 32'(shadow2), 0);
    chk("mid_reset_redirect", 32'(redirect), 0);
    chk("mid_reset_redirect_pc", 32'(redirect_pc), 0);
    check_counts("mid_reset");
    tick();
    chk("post_reset_shadow2", 32'(shadow2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
